// File: rtl/fc_layer_stream_if.sv
// fc_layer_stream_if: weight-load, input-beat and output-vector handshake bundle for fc_layer_stream.
interface fc_layer_stream_if #(
    parameter int OUT_NUM = 16,
    parameter int LANES   = 3,
    parameter int DATA_W  = 16,
    parameter int W_W     = 8
);
    logic                      i_w_valid;
    logic [W_W-1:0]            i_w_data;
    logic                      o_w_done;
    logic                      i_valid;
    logic                      o_in_ready;
    logic [LANES*DATA_W-1:0]   i_data;
    logic                      o_valid;
    logic                      i_ready;
    logic [OUT_NUM*DATA_W-1:0] o_data;

    modport master (
        output i_w_valid, i_w_data, i_valid, i_data, i_ready,
        input  o_w_done, o_in_ready, o_valid, o_data
    );

    modport slave (
        input  i_w_valid, i_w_data, i_valid, i_data, i_ready,
        output o_w_done, o_in_ready, o_valid, o_data
    );
endinterface

// File: rtl/fc_layer_stream.sv
// fc_layer_stream: streamed int8 fully-connected layer with requantise and activation.
// Define FC_LAYER_RELU_EN for ReLU output; otherwise outputs are signed-saturated.
module fc_layer_stream #(
    parameter int IN_NUM  = 48,
    parameter int OUT_NUM = 16,
    parameter int LANES   = 3,
    parameter int DATA_W  = 16,
    parameter int W_W     = 8,
    parameter int ACC_W   = 32,
    parameter int SHIFT   = 8
) (
    input logic i_clk,
    input logic i_rst,
    fc_layer_stream_if.slave bus
);
    localparam int BEATS = IN_NUM / LANES;
    localparam int NW    = IN_NUM * OUT_NUM;
    localparam int NTOT  = NW + OUT_NUM;
    localparam int WC_W  = $clog2(NTOT + 1);
    localparam int BT_W  = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) <<< (DATA_W - 1)) - 1;
    localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - 1;

    if (IN_NUM % LANES != 0) begin : g_chk
        $error("IN_NUM must be a multiple of LANES");
    end

    typedef enum logic [1:0] {LOAD, ACC, FINAL, OUT} state_t;

    state_t                   state_q, state_d;
    logic [WC_W-1:0]          w_cnt_q, w_cnt_d;
    logic [BT_W-1:0]          beat_q, beat_d;
    logic                     w_done_q, w_done_d;
    logic signed [ACC_W-1:0]  acc_q [OUT_NUM];
    logic signed [ACC_W-1:0]  acc_d [OUT_NUM];
    logic [OUT_NUM*DATA_W-1:0] o_data_q, o_data_d;
    logic signed [W_W-1:0]    mem [NTOT];
    logic signed [DATA_W-1:0] lane [LANES];
    logic signed [ACC_W-1:0]  beat_sum [OUT_NUM];
    logic signed [ACC_W-1:0]  r [OUT_NUM];

    function automatic logic [DATA_W-1:0] act(input logic signed [ACC_W-1:0] v);
`ifdef FC_LAYER_RELU_EN
        return v < 0 ? '0 : v > MAX_V ? DATA_W'(MAX_V) : v[DATA_W-1:0];
`else
        return v > MAX_V ? DATA_W'(MAX_V) : v < MIN_V ? DATA_W'(MIN_V) : v[DATA_W-1:0];
`endif
    endfunction

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane[k] = bus.i_data[k*DATA_W +: DATA_W];
    end

    // Weights and biases share one byte RAM in stream order; it is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_rst && state_q == LOAD && bus.i_w_valid) mem[w_cnt_q] <= bus.i_w_data;
    end

    always_comb begin
        for (int o = 0; o < OUT_NUM; o++) begin
            beat_sum[o] = '0;
            for (int k = 0; k < LANES; k++)
                beat_sum[o] = beat_sum[o] + ACC_W'(lane[k]) *
                    ACC_W'(mem[WC_W'(o*IN_NUM + k) + WC_W'(beat_q*LANES)]);
            r[o] = (acc_q[o] + (ACC_W'(mem[WC_W'(NW + o)]) <<< SHIFT)) >>> SHIFT;
        end
    end

    always_comb begin
        state_d  = state_q;
        w_cnt_d  = w_cnt_q;
        beat_d   = beat_q;
        w_done_d = w_done_q;
        acc_d    = acc_q;
        o_data_d = o_data_q;
        case (state_q)
            LOAD: if (bus.i_w_valid) begin
                w_cnt_d = w_cnt_q + 1'b1;
                if (w_cnt_q == WC_W'(NTOT - 1)) begin
                    w_done_d = 1'b1;
                    state_d  = ACC;
                end
            end
            ACC: if (bus.i_valid) begin
                for (int o = 0; o < OUT_NUM; o++) acc_d[o] = acc_q[o] + beat_sum[o];
                beat_d  = beat_q == BT_W'(BEATS - 1) ? '0 : beat_q + 1'b1;
                state_d = beat_q == BT_W'(BEATS - 1) ? FINAL : ACC;
            end
            FINAL: begin
                for (int o = 0; o < OUT_NUM; o++) o_data_d[o*DATA_W +: DATA_W] = act(r[o]);
                state_d = OUT;
            end
            OUT: if (bus.i_ready) begin
                for (int o = 0; o < OUT_NUM; o++) acc_d[o] = '0;
                beat_d  = '0;
                state_d = ACC;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= LOAD;
            w_cnt_q  <= '0;
            beat_q   <= '0;
            w_done_q <= 1'b0;
            o_data_q <= '0;
            for (int o = 0; o < OUT_NUM; o++) acc_q[o] <= '0;
        end else begin
            state_q  <= state_d;
            w_cnt_q  <= w_cnt_d;
            beat_q   <= beat_d;
            w_done_q <= w_done_d;
            o_data_q <= o_data_d;
            acc_q    <= acc_d;
        end
    end

    assign bus.o_w_done   = w_done_q;
    assign bus.o_in_ready = state_q == ACC;
    assign bus.o_valid    = state_q == OUT;
    assign bus.o_data     = o_data_q;
endmodule
